// File: rtl/matrix_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_window_ctrl
// Purpose  : Frame/window sequencer for the 3x3 matrix path. Follows CMOS
//            vsync/href on the pixel clock, numbers the pixels of the
//            IMG_HDISP x IMG_VDISP active window and gates line-buffer writes
//            so that only in-window pixels reach the matrix generator. Also
//            reports line/frame geometry errors, end of frame and a frame
//            counter.
// Ports    : clk               in   pixel clock (cmos_pclk)
//            rst_n             in   asynchronous active-low reset
//            per_frame_vsync   in   CMOS vsync, active == CMOS_VSYNC_VALID
//            per_frame_href    in   CMOS href, high = valid pixel
//            lb_wr_en          out  line-buffer write/shift enable
//            pix_x / pix_y     out  column/row of the pixel under lb_wr_en
//            border_l/r/t/b    out  pixel sits on the left/right/top/bottom
//                                   edge of the window
//            frame_busy        out  sequencer is inside a frame (SYNC/ACTIVE)
//            frame_done        out  one-cycle end-of-frame pulse
//            line_err          out  sticky: a line length differed from
//                                   IMG_HDISP (cleared at next frame start)
//            frame_err         out  valid with frame_done: bad frame geometry
//            frame_cnt         out  completed frames, wraps 255 -> 0
// Revision : 1.0  initial release
// ============================================================================
module matrix_window_ctrl #(
  parameter logic [9:0] IMG_HDISP        = 10'd640,
  parameter logic [9:0] IMG_VDISP        = 10'd480,
  parameter logic       CMOS_VSYNC_VALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  output logic       lb_wr_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       border_l,
  output logic       border_r,
  output logic       border_t,
  output logic       border_b,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_SYNC      = 3'd2;
  localparam logic [2:0] S_ACTIVE    = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [9:0] CNT_MAX     = 10'h3FF;

  // Counters stop at full scale so a runaway line/frame cannot wrap back
  // into the window and produce bogus writes.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // --------------------------------------------------------------------------
  logic vs_act;
  logic vs_d_q, vs_d2_q;
  logic hr_d_q, hr_d2_q;
  logic vs_rise, vs_fall, hr_rise, hr_fall;

  assign vs_act  = (per_frame_vsync == CMOS_VSYNC_VALID);
  assign vs_rise =  vs_d_q & ~vs_d2_q;
  assign vs_fall = ~vs_d_q &  vs_d2_q;
  assign hr_rise =  hr_d_q & ~hr_d2_q;
  assign hr_fall = ~hr_d_q &  hr_d2_q;

  // --------------------------------------------------------------------------
  // State, counters and output registers
  // --------------------------------------------------------------------------
  logic [2:0] state_q,     state_d;
  logic [9:0] h_cnt_q,     h_cnt_d;
  logic [9:0] v_cnt_q,     v_cnt_d;
  logic       line_err_q,  line_err_d;
  logic       trunc_q,     trunc_d;      // vsync ended while a line was live
  logic       lb_wr_en_q,  lb_wr_en_d;
  logic [9:0] pix_x_q,     pix_x_d;
  logic [9:0] pix_y_q,     pix_y_d;
  logic       border_l_q,  border_l_d;
  logic       border_r_q,  border_r_d;
  logic       border_t_q,  border_t_d;
  logic       border_b_q,  border_b_d;
  logic       frame_busy_q, frame_busy_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q,  frame_err_d;
  logic [7:0] frame_cnt_q,  frame_cnt_d;

  logic       in_frame;
  logic       in_window;

  assign in_frame  = (state_q == S_SYNC) || (state_q == S_ACTIVE);
  assign in_window = in_frame && hr_d_q &&
                     (h_cnt_q < IMG_HDISP) && (v_cnt_q < IMG_VDISP);

  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    line_err_d   = line_err_q;
    trunc_d      = trunc_q;
    lb_wr_en_d   = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    border_l_d   = border_l_q;
    border_r_d   = border_r_q;
    border_t_d   = border_t_q;
    border_b_d   = border_b_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // Pixel qualification: coordinates and border flags only move when a
    // write is issued, so downstream sees them held between pixels.
    if (in_window) begin
      lb_wr_en_d = 1'b1;
      pix_x_d    = h_cnt_q;
      pix_y_d    = v_cnt_q;
      border_l_d = (h_cnt_q == 10'd0);
      border_r_d = (h_cnt_q == IMG_HDISP - 10'd1);
      border_t_d = (v_cnt_q == 10'd0);
      border_b_d = (v_cnt_q == IMG_VDISP - 10'd1);
    end

    // Geometry counting only runs inside a frame; href outside is ignored.
    if (in_frame) begin
      if (hr_d_q) begin
        h_cnt_d = sat_inc(h_cnt_q);
      end
      if (hr_fall) begin
        // Line closes before any same-cycle vsync fall is judged in DONE.
        if (h_cnt_q != IMG_HDISP) begin
          line_err_d = 1'b1;
        end
        h_cnt_d = 10'd0;
        v_cnt_d = sat_inc(v_cnt_q);
      end else if (vs_fall && hr_d_q) begin
        // Frame ended with href still high: count the cut line and flag it.
        trunc_d = 1'b1;
        h_cnt_d = 10'd0;
        v_cnt_d = sat_inc(v_cnt_q);
      end
    end

    case (state_q)
      S_WAIT_IDLE: begin
        // Both the live and registered vsync must be inactive so that a
        // frame already running at reset release cannot fake a rising edge.
        if (!vs_act && !vs_d_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (vs_rise) begin
          state_d    = S_SYNC;
          line_err_d = 1'b0;
          trunc_d    = 1'b0;
          h_cnt_d    = 10'd0;
          v_cnt_d    = 10'd0;
        end
      end
      S_SYNC: begin
        if (vs_fall) begin
          state_d = S_DONE;
        end else if (hr_rise) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vs_fall) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
        frame_err_d  = (v_cnt_q != IMG_VDISP) || trunc_q || line_err_q;
        frame_cnt_d  = frame_cnt_q + 8'd1;
      end
      default: begin
        state_d = S_WAIT_IDLE;
      end
    endcase

    frame_busy_d = (state_d == S_SYNC) || (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_q       <= 1'b0;
      vs_d2_q      <= 1'b0;
      hr_d_q       <= 1'b0;
      hr_d2_q      <= 1'b0;
      state_q      <= S_WAIT_IDLE;
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      line_err_q   <= 1'b0;
      trunc_q      <= 1'b0;
      lb_wr_en_q   <= 1'b0;
      pix_x_q      <= 10'd0;
      pix_y_q      <= 10'd0;
      border_l_q   <= 1'b0;
      border_r_q   <= 1'b0;
      border_t_q   <= 1'b0;
      border_b_q   <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      vs_d_q       <= vs_act;
      vs_d2_q      <= vs_d_q;
      hr_d_q       <= per_frame_href;
      hr_d2_q      <= hr_d_q;
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      line_err_q   <= line_err_d;
      trunc_q      <= trunc_d;
      lb_wr_en_q   <= lb_wr_en_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      border_l_q   <= border_l_d;
      border_r_q   <= border_r_d;
      border_t_q   <= border_t_d;
      border_b_q   <= border_b_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign lb_wr_en   = lb_wr_en_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign border_l   = border_l_q;
  assign border_r   = border_r_q;
  assign border_t   = border_t_q;
  assign border_b   = border_b_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_window_ctrl
// Purpose  : Directed bench for matrix_window_ctrl on a 16x5 window.
// Revision : 1.0  initial release
// ============================================================================
module tb_matrix_window_ctrl;

  localparam logic [9:0] HD = 10'd16;
  localparam logic [9:0] VD = 10'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       lb_wr_en;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       border_l, border_r, border_t, border_b;
  logic       frame_busy, frame_done, line_err, frame_err;
  logic [7:0] frame_cnt;

  matrix_window_ctrl #(
    .IMG_HDISP        (HD),
    .IMG_VDISP        (VD),
    .CMOS_VSYNC_VALID (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (vsync),
    .per_frame_href  (href),
    .lb_wr_en        (lb_wr_en),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .border_l        (border_l),
    .border_r        (border_r),
    .border_t        (border_t),
    .border_b        (border_b),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done),
    .line_err        (line_err),
    .frame_err       (frame_err),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pixel-stream recorder: expected coordinates follow raster order over a
  // 16-wide window, restarting at each frame-start mark.
  logic sof_mark = 1'b0;
  int   wr_total = 0;
  int   done_total = 0;
  int   seq_bad = 0;
  int   brd_bad = 0;
  int   max_y = 0;
  int   ridx = 0;
  logic last_ferr = 1'b0;
  logic busy_mid = 1'b0;

  always @(negedge clk) begin
    int ex, ey;
    if (sof_mark) begin
      ridx  = 0;
      max_y = 0;
    end
    if (lb_wr_en === 1'b1) begin
      ex = ridx % 16;
      ey = ridx / 16;
      wr_total++;
      if (pix_x !== ex[9:0] || pix_y !== ey[9:0]) seq_bad++;
      if (border_l !== (ex == 0) || border_r !== (ex == 15) ||
          border_t !== (ey == 0) || border_b !== (ey == 4)) brd_bad++;
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
      ridx++;
    end
    if (frame_done === 1'b1) begin
      done_total++;
      last_ferr = frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int npix, input int gap);
    href = 1'b1;
    repeat (npix) tick();
    href = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic frame_open();
    vsync    = 1'b1;
    sof_mark = 1'b1;
    tick();
    sof_mark = 1'b0;
    tick();
    tick();
  endtask

  // long_idx selects one line of length long_len; -1 means all lines are 16.
  task automatic send_frame(input int nlines, input int long_idx, input int long_len);
    frame_open();
    for (int l = 0; l < nlines; l++) begin
      send_line((l == long_idx) ? long_len : 16, 3);
      if (l == 0) busy_mid = frame_busy;
    end
    vsync = 1'b0;
    repeat (6) tick();
  endtask

  int wr0, dn0, sq0, bd0;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_lb_wr_en",  lb_wr_en, 0);
    chk("rst_pix_xy",    {pix_x, pix_y}, 0);
    chk("rst_borders",   {border_l, border_r, border_t, border_b}, 0);
    chk("rst_flags",     {frame_busy, frame_done, line_err, frame_err}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // ---------------- href with vsync inactive ----------------
    wr0 = wr_total; dn0 = done_total;
    send_line(16, 3); send_line(16, 3); send_line(16, 3);
    chk("idle_href_wr",   wr_total - wr0, 0);
    chk("idle_href_busy", frame_busy, 0);
    chk("idle_href_done", done_total - dn0, 0);

    // ---------------- nominal 16x5 frame ----------------
    wr0 = wr_total; dn0 = done_total; sq0 = seq_bad; bd0 = brd_bad;
    send_frame(5, -1, 0);
    chk("nom_wr_cnt",    wr_total - wr0, 80);
    chk("nom_seq",       seq_bad - sq0, 0);
    chk("nom_border",    brd_bad - bd0, 0);
    chk("nom_max_y",     max_y, 4);
    chk("nom_done",      done_total - dn0, 1);
    chk("nom_frame_err", last_ferr, 0);
    chk("nom_line_err",  line_err, 0);
    chk("nom_frame_cnt", frame_cnt, 1);
    chk("nom_busy_mid",  busy_mid, 1);
    chk("nom_busy_end",  frame_busy, 0);

    // ---------------- line 2 carries 18 pixels ----------------
    wr0 = wr_total; dn0 = done_total; sq0 = seq_bad; bd0 = brd_bad;
    send_frame(5, 2, 18);
    chk("long_wr_cnt",    wr_total - wr0, 80);
    chk("long_seq",       seq_bad - sq0, 0);
    chk("long_border",    brd_bad - bd0, 0);
    chk("long_frame_err", last_ferr, 1);
    chk("long_line_err",  line_err, 1);
    chk("long_frame_cnt", frame_cnt, 2);

    // ---------------- clean frame clears line_err ----------------
    dn0 = done_total;
    send_frame(5, -1, 0);
    chk("clean_line_err",  line_err, 0);
    chk("clean_frame_err", last_ferr, 0);
    chk("clean_done",      done_total - dn0, 1);

    // ---------------- six lines: sixth suppressed ----------------
    wr0 = wr_total; sq0 = seq_bad;
    send_frame(6, -1, 0);
    chk("six_wr_cnt",    wr_total - wr0, 80);
    chk("six_max_y",     max_y, 4);
    chk("six_seq",       seq_bad - sq0, 0);
    chk("six_frame_err", last_ferr, 1);
    chk("six_frame_cnt", frame_cnt, 4);

    // ---------------- vsync drops during line 4, pixel 7 ----------------
    wr0 = wr_total; dn0 = done_total; sq0 = seq_bad;
    frame_open();
    for (int l = 0; l < 3; l++) send_line(16, 3);
    href = 1'b1;
    repeat (7) tick();
    vsync = 1'b0;
    repeat (3) tick();
    href = 1'b0;
    repeat (6) tick();
    chk("trunc_wr_cnt",    wr_total - wr0, 56);
    chk("trunc_seq",       seq_bad - sq0, 0);
    chk("trunc_done",      done_total - dn0, 1);
    chk("trunc_frame_err", last_ferr, 1);
    chk("trunc_busy",      frame_busy, 0);
    chk("trunc_frame_cnt", frame_cnt, 5);
    sq0 = seq_bad;
    send_frame(5, -1, 0);
    chk("after_trunc_seq", seq_bad - sq0, 0);
    chk("after_trunc_err", last_ferr, 0);

    // ---------------- reset mid-frame ----------------
    frame_open();
    send_line(16, 3);
    send_line(16, 3);
    href = 1'b1;
    repeat (5) tick();
    chk("pre_rst_wr_en", lb_wr_en, 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_wr_en",  lb_wr_en, 0);
    chk("async_rst_cnt",    frame_cnt, 0);
    chk("async_rst_pix",    {pix_x, pix_y}, 0);
    chk("async_rst_busy",   frame_busy, 0);
    tick();
    rst_n = 1'b1;
    wr0 = wr_total; dn0 = done_total;
    repeat (10) tick();
    href = 1'b0;
    repeat (3) tick();
    send_line(16, 3);
    send_line(16, 3);
    vsync = 1'b0;
    repeat (6) tick();
    chk("post_rst_wr",   wr_total - wr0, 0);
    chk("post_rst_done", done_total - dn0, 0);
    chk("post_rst_cnt",  frame_cnt, 0);
    wr0 = wr_total; sq0 = seq_bad;
    send_frame(5, -1, 0);
    chk("rst_next_wr",  wr_total - wr0, 80);
    chk("rst_next_seq", seq_bad - sq0, 0);
    chk("rst_next_err", last_ferr, 0);
    chk("rst_next_cnt", frame_cnt, 1);

    // ---------------- frame counter wrap ----------------
    wr0 = wr_total; dn0 = done_total;
    repeat (254) send_frame(5, -1, 0);
    chk("wrap_cnt_255", frame_cnt, 255);
    send_frame(5, -1, 0);
    chk("wrap_cnt_0",   frame_cnt, 0);
    send_frame(5, -1, 0);
    chk("wrap_cnt_1",   frame_cnt, 1);
    chk("wrap_done",    done_total - dn0, 256);
    chk("wrap_wr",      wr_total - wr0, 256 * 80);
    chk("wrap_err",     last_ferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_window_ctrl.md
Name: matrix_window_ctrl

Overview:
Frame/window sequencer for the 3X3 matrix path. Tracks CMOS vsync/href on the pixel clock and produces pixel coordinates and window border flags. Gates line-buffer writes so only the configured IMG_HDISP x IMG_VDISP area reaches the matrix generator, and reports geometry errors plus end-of-frame. Sits between the CMOS capture interface and Matrix_Generate_3X3, on cmos_pclk.

Parameters:
IMG_HDISP, 10'd640, active pixels per line
IMG_VDISP, 10'd480, active lines per frame
CMOS_VSYNC_VALID, 1'b1, vsync level meaning "frame active"

Ports:
clk  in  1  pixel clock (cmos_pclk)
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  CMOS vsync; active when equal to CMOS_VSYNC_VALID
per_frame_href  in  1  CMOS href, high = valid pixel
lb_wr_en  out  1  line-buffer write/shift enable for the matrix generator
pix_x  out  10  column of the pixel qualified by lb_wr_en
pix_y  out  10  row of the pixel qualified by lb_wr_en
border_l / border_r / border_t / border_b  out  1 each  pixel is in column 0 / column IMG_HDISP-1 / row 0 / row IMG_VDISP-1
frame_busy  out  1  high in SYNC and ACTIVE states
frame_done  out  1  one-cycle pulse at end of frame
line_err  out  1  sticky: some line length differed from IMG_HDISP; cleared at next frame start
frame_err  out  1  valid with frame_done: line count differed from IMG_VDISP, or vsync ended mid-line
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: all outputs 0, internal counters 0, FSM in WAIT_IDLE.
- vs_act = (per_frame_vsync == CMOS_VSYNC_VALID). vs_act and href are registered once (vs_d, hr_d). Edges are detected on the registered versions.
- FSM states:
  - WAIT_IDLE: wait for vs_act = 0, then go to IDLE. This stops a frame already in progress at reset release from being captured.
  - IDLE: on a vs_act rising edge, go to SYNC. In the same cycle: clear line_err, h_cnt and v_cnt.
  - SYNC: on the first href rising edge, go to ACTIVE. On vs_act falling with no lines, go to DONE.
  - ACTIVE: on vs_act falling, go to DONE.
  - DONE: one cycle, then IDLE.
- h_cnt increments on each sampled href = 1. It resets to 0 on the href falling edge, and v_cnt increments at that same edge. Both counters saturate at 1023.
- Pixel gating: a pixel is in-window when state is SYNC or ACTIVE, href = 1, h_cnt < IMG_HDISP and v_cnt < IMG_VDISP.
- Outputs are registered. lb_wr_en, pix_x, pix_y and the border flags appear 1 cycle after the pixel is sampled on per_frame_href (total 2 clk from the input pin). They are valid only while lb_wr_en = 1 and held otherwise.
- Line end (href falling edge): if h_cnt != IMG_HDISP, set line_err.
  - Long lines: pixels beyond IMG_HDISP are suppressed (lb_wr_en = 0).
  - Short lines are passed as-is.
- DONE state:
  - frame_done = 1 for one cycle.
  - frame_err = 1 for that same cycle if any of:
    - v_cnt != IMG_VDISP;
    - href was still high when vs_act fell (the truncated line is counted);
    - line_err is set.
  - frame_cnt increments.
- Lines with v_cnt >= IMG_VDISP are suppressed entirely.
- href while in IDLE or WAIT_IDLE is ignored: no lb_wr_en, no counting.
- frame_busy = (state == SYNC or state == ACTIVE), registered.
- Simultaneous vs_act falling and href falling: the line completes first (v_cnt++ and the line check), then DONE evaluates with the updated v_cnt.
- Reset mid-frame: asynchronous clear. The FSM returns to WAIT_IDLE and the partial frame is discarded (no frame_done).

Test Plan:
- Nominal 16x5 frame, vsync high, 16-pixel href bursts, 5 lines:
  - lb_wr_en high 80 cycles total; pix_x runs 0..15 and pix_y 0..4.
  - border_t only on y=0, border_r only on x=15.
  - frame_done once, frame_err=0, line_err=0, frame_cnt=1.
- Line 2 carries 18 pixels: pixels 16,17 give no lb_wr_en; line_err=1 sticky; frame_err=1 at frame_done; the next clean frame clears line_err.
- 6 lines sent: sixth line fully suppressed; frame_err=1 (v_cnt=6); pix_y never exceeds 4.
- vsync drops during line 4 (pixel 7): line truncated; frame_done with frame_err=1; FSM returns to IDLE; the next frame starts with pix_y=0.
- Reset asserted mid-frame while vsync is still high: outputs go to 0 immediately. After release, the remaining lines of that frame give no lb_wr_en. The following full frame is processed normally with frame_cnt=1.
- href pulses with vsync inactive, plus 256 clean frames: no lb_wr_en outside frames, and frame_cnt wraps from 255 to 0.
